// File: rtl/updown_bcd_counter_n_pkg.sv
// Shared definitions for the N-digit BCD up/down counter: FSM states,
// 7-segment patterns and BCD helpers.
package updown_bcd_counter_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg7_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/updown_bcd_counter_n_seg7.sv
// Combinational BCD to 7-segment decoder; codes 0xA-0xF decode to blank.
module updown_bcd_counter_n_seg7
    import updown_bcd_counter_n_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = seg7_pattern(i_bcd);

endmodule

// File: rtl/updown_bcd_counter_n.sv
// N-digit BCD up/down counter with start/pause FSM, parallel load, wrap/stop
// mode and a registered, glitch-free multiplexed 7-segment driver.
module updown_bcd_counter_n
    import updown_bcd_counter_n_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int TICK_DIV    = 12_500_000,
    parameter int REFRESH_DIV = 125_000,
    parameter int WRAP        = 0,
    parameter int SEG_ACT_LOW = 0,
    parameter int AN_ACT_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  rst_btn,
    input  logic                  start_btn,
    input  logic                  sw,
    input  logic                  load_en,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   count_debug,
    output logic                  running,
    output logic                  done
);

    localparam int CW = 4 * DIGITS;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0]     REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [CW-1:0]     ALL_NINES = {DIGITS{4'h9}};
    localparam logic [6:0]        SEG_MASK  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_MASK   = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : '0;
    localparam logic [DIGITS-1:0] AN_RESET  = DIGITS'(1) ^ AN_MASK;

    logic            r_s1, r_s2, r_s3;
    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_count;
    logic [TW-1:0]   r_presc;
    logic [RW-1:0]   r_ref;
    logic [IW-1:0]   r_idx;
    logic [6:0]      r_seg;
    logic [DIGITS-1:0] r_an;
    logic            r_running;
    logic            r_done;

    logic            w_start;
    logic            w_tick;
    logic            w_terminal;
    logic [CW-1:0]   w_preset;
    logic [CW-1:0]   w_stepped;
    logic [CW-1:0]   w_loaded;
    logic [CW-1:0]   w_count_next;
    logic            w_carry;
    logic [3:0]      w_dig;
    logic            w_do_load, w_do_preset, w_do_step, w_done;
    logic            w_presc_clr, w_presc_run;
    logic            w_ref_wrap;
    logic [IW-1:0]   w_idx_next;
    logic [3:0]      w_sel_digit;
    logic [6:0]      w_seg_dec;
    logic [DIGITS-1:0] w_an_next;

    // Start button: two-flop synchroniser plus edge register.
    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= start_btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_start    = r_s2 & ~r_s3;
    assign w_tick     = (r_presc == TICK_LAST);
    assign w_preset   = sw ? ALL_NINES : '0;
    assign w_terminal = sw ? (r_count == '0) : (r_count == ALL_NINES);

    for (genvar g = 0; g < DIGITS; g++) begin : g_load
        assign w_loaded[4*g +: 4] = bcd_clamp(load_val[4*g +: 4]);
    end

    // Ripple carry (up) / borrow (down) through the digits, LSD first.
    always_comb begin
        w_stepped = r_count;
        w_carry   = 1'b1;
        w_dig     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig = r_count[4*i +: 4];
            if (w_carry) begin
                if (!sw) begin
                    w_carry            = (w_dig == 4'd9);
                    w_stepped[4*i +: 4] = w_carry ? 4'd0 : w_dig + 4'd1;
                end else begin
                    w_carry            = (w_dig == 4'd0);
                    w_stepped[4*i +: 4] = w_carry ? 4'd9 : w_dig - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Load beats start in the same cycle; a start pulse in RUN beats a tick.
    always_comb begin
        w_state_next = r_state;
        w_do_load    = 1'b0;
        w_do_preset  = 1'b0;
        w_do_step    = 1'b0;
        w_done       = 1'b0;
        w_presc_clr  = 1'b0;
        w_presc_run  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_en) begin
                    w_do_load = 1'b1;
                end else if (w_start) begin
                    w_state_next = ST_RUN;
                    w_do_preset  = 1'b1;
                    w_presc_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_start) begin
                    w_state_next = ST_PAUSE;
                end else begin
                    w_presc_run = 1'b1;
                    if (w_tick) begin
                        if (w_terminal) begin
                            w_done = 1'b1;
                            if (WRAP != 0) w_do_preset  = 1'b1;
                            else           w_state_next = ST_DONE;
                        end else begin
                            w_do_step = 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (load_en) begin
                    w_do_load = 1'b1;
                end else if (w_start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load_en) begin
                    w_do_load    = 1'b1;
                    w_state_next = ST_PAUSE;
                end else if (w_start) begin
                    w_state_next = ST_RUN;
                    w_do_preset  = 1'b1;
                    w_presc_clr  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        if (w_do_load)        w_count_next = w_loaded;
        else if (w_do_preset) w_count_next = w_preset;
        else if (w_do_step)   w_count_next = w_stepped;
    end

    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) begin
            r_count   <= '0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_running <= (w_state_next == ST_RUN);
            r_done    <= w_done;
            if (w_presc_clr)
                r_presc <= '0;
            else if (w_presc_run)
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    assign w_ref_wrap = (r_ref == REF_LAST);
    assign w_idx_next = !w_ref_wrap ? r_idx :
                        (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

    // Decode from next-cycle count and index so an/seg land together with count.
    always_comb begin
        w_sel_digit = 4'd0;
        w_an_next   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_an_next[i] = (w_idx_next == IW'(i));
            if (w_idx_next == IW'(i)) w_sel_digit = w_count_next[4*i +: 4];
        end
    end

    updown_bcd_counter_n_seg7 u_seg7 (
        .i_bcd (w_sel_digit),
        .o_seg (w_seg_dec)
    );

    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) begin
            r_ref <= '0;
            r_idx <= '0;
            r_seg <= seg7_pattern(4'd0) ^ SEG_MASK;
            r_an  <= AN_RESET;
        end else begin
            r_ref <= w_ref_wrap ? '0 : r_ref + 1'b1;
            r_idx <= w_idx_next;
            r_seg <= w_seg_dec ^ SEG_MASK;
            r_an  <= w_an_next ^ AN_MASK;
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign count_debug = r_count;
    assign running     = r_running;
    assign done        = r_done;

endmodule

// File: tb/tb_updown_bcd_counter_n.sv
// Directed bench for updown_bcd_counter_n: stop and wrap instances side by side.
module tb_updown_bcd_counter_n;

    logic       clk = 1'b0;
    logic       rst_btn, start_btn, sw, load_en;
    logic [7:0] load_val;
    logic [6:0] seg_a, seg_w;
    logic [1:0] an_a, an_w;
    logic [7:0] cnt_a, cnt_w;
    logic       run_a, run_w, done_a, done_w;

    int n_checks = 0;
    int n_errors = 0;
    int dcnt_a = 0;
    int dcnt_w = 0;
    int d0;

    always #4 clk = ~clk;

    updown_bcd_counter_n #(
        .DIGITS(2), .TICK_DIV(4), .REFRESH_DIV(2),
        .WRAP(0), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)
    ) dut_a (
        .clk(clk), .rst_btn(rst_btn), .start_btn(start_btn), .sw(sw),
        .load_en(load_en), .load_val(load_val), .seg(seg_a), .an(an_a),
        .count_debug(cnt_a), .running(run_a), .done(done_a)
    );

    updown_bcd_counter_n #(
        .DIGITS(2), .TICK_DIV(4), .REFRESH_DIV(2),
        .WRAP(1), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)
    ) dut_w (
        .clk(clk), .rst_btn(rst_btn), .start_btn(start_btn), .sw(sw),
        .load_en(load_en), .load_val(load_val), .seg(seg_w), .an(an_w),
        .count_debug(cnt_w), .running(run_w), .done(done_w)
    );

    always @(posedge clk) begin
        if (done_a) dcnt_a <= dcnt_a + 1;
        if (done_w) dcnt_w <= dcnt_w + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    task automatic press_start();
        start_btn = 1'b1;
        repeat (3) @(negedge clk);
        start_btn = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_btn = 1'b1;
        @(negedge clk);
        rst_btn = 1'b0;
    endtask

    task automatic load_once(input logic [7:0] v);
        load_val = v;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic step_to(input string tag, input bit use_w, input logic [7:0] exp);
        logic [7:0] prev;
        int k;
        prev = use_w ? cnt_w : cnt_a;
        k = 0;
        while (((use_w ? cnt_w : cnt_a) == prev) && k < 12) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, use_w ? cnt_w : cnt_a, exp);
    endtask

    initial begin
        rst_btn = 1'b1; start_btn = 1'b0; sw = 1'b0; load_en = 1'b0; load_val = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_cnt", cnt_a, 8'h00);
        check_eq("rst_run", run_a, 1'b0);
        check_eq("rst_done", done_a, 1'b0);
        check_eq("rst_an", an_a, 2'b01);
        check_eq("rst_seg", seg_a, 7'h3F);
        rst_btn = 1'b0;

        // Count up to terminal and stop.
        sw = 1'b0;
        d0 = dcnt_a;
        press_start();
        check_eq("t1_start_cnt", cnt_a, 8'h00);
        check_eq("t1_start_run", run_a, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("t1_pre_tick", cnt_a, 8'h00);
        @(negedge clk);
        check_eq("t1_first_tick", cnt_a, 8'h01);
        for (int v = 2; v <= 99; v++) step_to("t1_up", 1'b0, to_bcd(v));
        repeat (12) @(negedge clk);
        check_eq("t1_hold", cnt_a, 8'h99);
        check_eq("t1_run_off", run_a, 1'b0);
        check_eq("t1_done_once", dcnt_a - d0, 1);
        load_once(8'h0A);
        check_eq("t1_load_clamp", cnt_a, 8'h09);
        check_eq("t1_load_pause", run_a, 1'b0);
        press_start();
        check_eq("t1_resume_run", run_a, 1'b1);
        step_to("t1_after_load", 1'b0, 8'h10);

        // Count down from nines.
        sw = 1'b1;
        apply_reset();
        d0 = dcnt_a;
        press_start();
        check_eq("t2_preset", cnt_a, 8'h99);
        for (int v = 98; v >= 0; v--) step_to("t2_down", 1'b0, to_bcd(v));
        repeat (12) @(negedge clk);
        check_eq("t2_hold", cnt_a, 8'h00);
        check_eq("t2_run_off", run_a, 1'b0);
        check_eq("t2_done_once", dcnt_a - d0, 1);

        // Wrap mode.
        sw = 1'b0;
        apply_reset();
        d0 = dcnt_w;
        press_start();
        check_eq("t3_start", cnt_w, 8'h00);
        for (int v = 1; v <= 99; v++) step_to("t3_up", 1'b1, to_bcd(v));
        step_to("t3_wrap", 1'b1, 8'h00);
        check_eq("t3_still_run", run_w, 1'b1);
        step_to("t3_after_wrap", 1'b1, 8'h01);
        check_eq("t3_done_once", dcnt_w - d0, 1);

        // Pause and resume.
        apply_reset();
        press_start();
        for (int v = 1; v <= 37; v++) step_to("t4_up", 1'b0, to_bcd(v));
        press_start();
        check_eq("t4_paused_cnt", cnt_a, 8'h37);
        check_eq("t4_paused_run", run_a, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("t4_an_onehot", (an_a == 2'b01) || (an_a == 2'b10), 1'b1);
            check_eq("t4_seg_digit", seg_a, seg_ref(an_a == 2'b01 ? cnt_a[3:0] : cnt_a[7:4]));
        end
        repeat (32) @(negedge clk);
        check_eq("t4_held", cnt_a, 8'h37);
        press_start();
        check_eq("t4_res0", cnt_a, 8'h37);
        @(negedge clk);
        check_eq("t4_res1", cnt_a, 8'h37);
        @(negedge clk);
        check_eq("t4_resume_step", cnt_a, 8'h38);

        // Load in PAUSE with clamp, direction flip, load ignored in RUN.
        press_start();
        check_eq("t5_paused", cnt_a, 8'h38);
        load_once(8'h5C);
        check_eq("t5_load", cnt_a, 8'h59);
        press_start();
        step_to("t5_up", 1'b0, 8'h60);
        sw = 1'b1;
        step_to("t5_flip", 1'b0, 8'h59);
        load_once(8'h11);
        check_eq("t5_load_in_run", cnt_a, 8'h59);
        check_eq("t5_run_kept", run_a, 1'b1);
        step_to("t5_down", 1'b0, 8'h58);

        // Start and load together in IDLE, then async reset mid-count.
        sw = 1'b0;
        apply_reset();
        start_btn = 1'b1;
        repeat (2) @(negedge clk);
        load_once(8'h25);
        start_btn = 1'b0;
        check_eq("t6_load_wins", cnt_a, 8'h25);
        repeat (4) @(negedge clk);
        check_eq("t6_start_dropped", run_a, 1'b0);
        press_start();
        check_eq("t6_preset", cnt_a, 8'h00);
        for (int v = 1; v <= 42; v++) step_to("t6_up", 1'b0, to_bcd(v));
        #1 rst_btn = 1'b1;
        #1;
        check_eq("t6_async_cnt", cnt_a, 8'h00);
        check_eq("t6_async_run", run_a, 1'b0);
        check_eq("t6_async_done", done_a, 1'b0);
        check_eq("t6_async_an", an_a, 2'b01);
        check_eq("t6_async_seg", seg_a, 7'h3F);
        @(negedge clk);
        rst_btn  = 1'b0;
        load_val = 8'h73;
        load_en  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            load_en = 1'b0;
            check_eq("t6_mux_an", an_a, ((k / 2) % 2 != 0) ? 2'b10 : 2'b01);
            check_eq("t6_mux_seg", seg_a, ((k / 2) % 2 != 0) ? seg_ref(4'd7) : seg_ref(4'd3));
        end
        check_eq("t6_mux_cnt", cnt_a, 8'h73);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
